sky_mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer sitting between the XU pipeline and the one shared memory port. It arbitrates between instruction fetch and the load/store requests leaving the execute stage. Data requests get priority, with a starvation guard for fetch. It runs one outstanding transaction at a time through a three-state FSM, routes the response to its owner, and drives `data_stall` so the pipeline holds while a load/store is unresolved.

---
 rtl/sky_xu_pkg.sv | 17 +
 rtl/sky_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_sky_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sky_xu_pkg.sv
// Shared types and widths for the XU memory-side blocks.
package sky_xu_pkg;

    localparam int SKY_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } arb_owner_t;

endpackage

// File: rtl/sky_mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and load/store,
// with data priority and a starvation guard that eventually forces a fetch grant.
module sky_mem_arbiter
    import sky_xu_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [SKY_XLEN-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [SKY_XLEN-1:0] if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [SKY_XLEN-1:0] dm_addr,
    input  logic [SKY_XLEN-1:0] dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [SKY_XLEN-1:0] dm_rdata,
    output logic                data_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [SKY_XLEN-1:0] mem_addr,
    output logic [SKY_XLEN-1:0] mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [SKY_XLEN-1:0] mem_rdata,
    output logic                busy,
    output logic                proto_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t          state;
    arb_owner_t          owner;
    logic                we_q;
    logic [SKY_XLEN-1:0] addr_q;
    logic [SKY_XLEN-1:0] wdata_q;
    logic [SKY_XLEN-1:0] if_rdata_q;
    logic [SKY_XLEN-1:0] dm_rdata_q;
    logic [3:0]          starve_cnt;
    logic                mem_req_q;
    logic                busy_q;
    logic                proto_q;

    logic idle;
    logic resp;
    logic fetch_win;
    logic data_win;

    always_comb begin
        idle       = (state == IDLE);
        resp       = (state == WAIT) && mem_rvalid;
        // Fetch wins when alone, or when data has won LIMIT times in a row over it.
        fetch_win  = if_req && (!dm_req || (starve_cnt == LIMIT));
        data_win   = dm_req && !fetch_win;
        if_gnt     = idle && fetch_win;
        dm_gnt     = idle && data_win;
        if_rvalid  = resp && (owner == OWN_FETCH);
        dm_rvalid  = resp && (owner == OWN_DATA);
        if_rdata   = if_rvalid ? mem_rdata : if_rdata_q;
        dm_rdata   = dm_rvalid ? mem_rdata : dm_rdata_q;
        data_stall = dm_req || (!idle && (owner == OWN_DATA) && !resp);
        mem_req    = mem_req_q;
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        busy       = busy_q;
        proto_err  = proto_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_cnt <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            if (mem_rvalid && (state != WAIT)) proto_q <= 1'b1;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dm_rvalid) dm_rdata_q <= mem_rdata;

            case (state)
                IDLE: begin
                    if (!if_req || fetch_win) begin
                        starve_cnt <= '0;
                    end else if (data_win && (starve_cnt != 4'hF)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                    if (fetch_win || data_win) begin
                        owner     <= fetch_win ? OWN_FETCH : OWN_DATA;
                        we_q      <= fetch_win ? 1'b0 : dm_we;
                        addr_q    <= fetch_win ? if_addr : dm_addr;
                        wdata_q   <= fetch_win ? '0 : dm_wdata;
                        state     <= ISSUE;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        state     <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sky_mem_arbiter.sv
// Bench for sky_mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_sky_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, dm_req, dm_we, mem_ready, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, data_stall;
    logic        mem_req, mem_we, busy, proto_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    sky_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .data_stall(data_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (got=running, exp=finished)");
        $fatal(1);
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req, dm_we;
        logic [31:0] dm_addr, dm_wdata;
        logic        mem_ready, mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_if_gnt, e_dm_gnt, e_mem_req, e_mem_we;
        logic [31:0] e_mem_addr, e_mem_wdata;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_dm_rvalid;
        logic [31:0] e_dm_rdata;
        logic        e_stall, e_busy;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // reference model state (transaction level)
    bit          m_out, m_issued, m_own_data, m_we;
    bit          mem_pend, drop_if, drop_dm, fw, dw;
    int          m_starve, mem_cnt;
    logic [31:0] m_addr, m_wdata;
    string       seq;

    initial begin
        // fetch-only, then store; state carries from one row to the next
        tv[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        tv[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        tv[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1};
        tv[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 1'b0, 32'h0,
                  1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hA5, 1'b0, 1'b1};
        tv[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hA5, 1'b0, 1'b0};

        // reset values
        clr_in();
        reset_n = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);         chk("rst_proto", proto_err, 0);
        chk("rst_if_gnt", if_gnt, 0);     chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_if_rv", if_rvalid, 0);   chk("rst_dm_rv", dm_rvalid, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0); chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall", data_stall, 0);
        cyc();
        cyc();
        reset_n = 1;

        // directed vector table
        for (int i = 0; i < 9; i++) begin
            cyc();
            if_req = tv[i].if_req; if_addr = tv[i].if_addr;
            dm_req = tv[i].dm_req; dm_we = tv[i].dm_we;
            dm_addr = tv[i].dm_addr; dm_wdata = tv[i].dm_wdata;
            mem_ready = tv[i].mem_ready; mem_rvalid = tv[i].mem_rvalid; mem_rdata = tv[i].mem_rdata;
            #1;
            chk($sformatf("tv%0d_if_gnt", i), if_gnt, tv[i].e_if_gnt);
            chk($sformatf("tv%0d_dm_gnt", i), dm_gnt, tv[i].e_dm_gnt);
            chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].e_mem_req);
            if (tv[i].e_mem_req) begin
                chk($sformatf("tv%0d_mem_we", i), mem_we, tv[i].e_mem_we);
                chk($sformatf("tv%0d_mem_addr", i), mem_addr, tv[i].e_mem_addr);
                chk($sformatf("tv%0d_mem_wdata", i), mem_wdata, tv[i].e_mem_wdata);
            end
            chk($sformatf("tv%0d_if_rvalid", i), if_rvalid, tv[i].e_if_rvalid);
            chk($sformatf("tv%0d_if_rdata", i), if_rdata, tv[i].e_if_rdata);
            chk($sformatf("tv%0d_dm_rvalid", i), dm_rvalid, tv[i].e_dm_rvalid);
            chk($sformatf("tv%0d_dm_rdata", i), dm_rdata, tv[i].e_dm_rdata);
            chk($sformatf("tv%0d_stall", i), data_stall, tv[i].e_stall);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d_proto", i), proto_err, 0);
        end

        // contention: both held, expect starvation guard every LIMIT data wins
        cyc();
        clr_in();
        if_req = 1; if_addr = 32'h200; dm_req = 1; dm_addr = 32'h300;
        seq = "";
        for (int c = 0; c < 80 && seq.len() < 11; c++) begin
            if (c != 0) cyc();
            mem_ready  = mem_req;
            mem_rvalid = busy && !mem_req;
            #1;
            if (if_gnt && dm_gnt) seq = {seq, "B"};
            else if (if_gnt) seq = {seq, "F"};
            else if (dm_gnt) seq = {seq, "D"};
        end
        checks++;
        if (seq != "DDDDFDDDDFD") begin
            errors++;
            $display("FAIL contention_order got=%s exp=DDDDFDDDDFD", seq);
        end
        cyc();
        if_req = 0; dm_req = 0;
        for (int c = 0; c < 10 && busy; c++) begin
            mem_ready  = mem_req;
            mem_rvalid = busy && !mem_req;
            cyc();
        end
        clr_in();
        #1;
        chk("contention_drain_busy", busy, 0);

        // ISSUE held by mem_ready=0 for 5 cycles
        cyc();
        if_req = 1; if_addr = 32'h400;
        #1;
        chk("stall_if_gnt", if_gnt, 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h500; mem_ready = 0;
            #1;
            chk($sformatf("stall%0d_mem_req", k), mem_req, 1);
            chk($sformatf("stall%0d_mem_addr", k), mem_addr, 32'h400);
            chk($sformatf("stall%0d_dm_gnt", k), dm_gnt, 0);
            chk($sformatf("stall%0d_busy", k), busy, 1);
            chk($sformatf("stall%0d_dstall", k), data_stall, 1);
        end
        cyc();
        mem_ready = 1;
        #1;
        chk("stall_accept_req", mem_req, 1);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
        #1;
        chk("stall_if_rvalid", if_rvalid, 1);
        chk("stall_if_rdata", if_rdata, 32'h1234);
        chk("stall_dm_gnt_wait", dm_gnt, 0);
        cyc();
        mem_rvalid = 0;
        #1;
        chk("stall_dm_gnt_idle", dm_gnt, 1);
        cyc();
        dm_req = 0; mem_ready = 1;
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        #1;
        chk("stall_dm_rvalid", dm_rvalid, 1);
        chk("stall_dm_rdata", dm_rdata, 32'h77);
        chk("stall_if_rv_other", if_rvalid, 0);

        // unexpected response while idle
        cyc();
        clr_in();
        mem_rvalid = 1; mem_rdata = 32'hBAD;
        #1;
        chk("proto_if_rv", if_rvalid, 0);
        chk("proto_dm_rv", dm_rvalid, 0);
        chk("proto_if_rdata_hold", if_rdata, 32'h1234);
        chk("proto_dm_rdata_hold", dm_rdata, 32'h77);
        cyc();
        mem_rvalid = 0;
        #1;
        chk("proto_set", proto_err, 1);
        if_req = 1; if_addr = 32'h600;
        #1;
        chk("proto_after_gnt", if_gnt, 1);
        cyc();
        if_req = 0; mem_ready = 1;
        #1;
        chk("proto_after_addr", mem_addr, 32'h600);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
        #1;
        chk("proto_after_rvalid", if_rvalid, 1);
        chk("proto_after_rdata", if_rdata, 32'hCAFE);
        cyc();
        mem_rvalid = 0;
        #1;
        chk("proto_sticky", proto_err, 1);

        // reset during WAIT of a data load
        cyc();
        dm_req = 1; dm_we = 0; dm_addr = 32'h700;
        #1;
        chk("rstw_dm_gnt", dm_gnt, 1);
        cyc();
        dm_req = 0; mem_ready = 1;
        cyc();
        mem_ready = 0;
        #1;
        chk("rstw_busy_wait", busy, 1);
        reset_n = 0;
        #1;
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_proto", proto_err, 0);
        chk("rstw_stall", data_stall, 0);
        cyc();
        reset_n = 1;
        cyc();
        if_req = 1; if_addr = 32'h800;
        #1;
        chk("rstw_first_gnt", if_gnt, 1);
        cyc();
        if_req = 0; mem_ready = 1;
        cyc();
        mem_ready = 0; mem_rvalid = 1;
        cyc();
        clr_in();

        // random traffic vs transaction-level model
        m_out = 0; m_issued = 0; m_starve = 0; mem_pend = 0; mem_cnt = 0;
        drop_if = 0; drop_dm = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (drop_if) if_req = 0;
            if (drop_dm) dm_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            mem_ready  = mem_req && ($urandom_range(0, 1) == 1);
            mem_rvalid = mem_pend && (mem_cnt == 0);
            mem_rdata  = $urandom;
            #1;
            fw = !m_out && if_req && (!dm_req || m_starve == int'(LIMIT));
            dw = !m_out && dm_req && !fw;
            chk("rnd_if_gnt", if_gnt, fw);
            chk("rnd_dm_gnt", dm_gnt, dw);
            chk("rnd_busy", busy, m_out);
            chk("rnd_mem_req", mem_req, m_out && !m_issued);
            chk("rnd_stall", data_stall, dm_req || (m_out && m_own_data && !mem_rvalid));
            if (mem_req) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_if_rvalid", if_rvalid, mem_rvalid && !m_own_data);
            chk("rnd_dm_rvalid", dm_rvalid, mem_rvalid && m_own_data);
            if (mem_rvalid && !m_own_data) chk("rnd_if_rdata", if_rdata, mem_rdata);
            if (mem_rvalid && m_own_data) chk("rnd_dm_rdata", dm_rdata, mem_rdata);

            drop_if = if_gnt;
            drop_dm = dm_gnt;
            if (!m_out) begin
                if (!if_req || fw) m_starve = 0;
                else if (dw) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                if (fw || dw) begin
                    m_out = 1; m_issued = 0; m_own_data = dw;
                    m_we = dw && dm_we;
                    m_addr = fw ? if_addr : dm_addr;
                    m_wdata = dm_wdata;
                end
            end else if (!m_issued && mem_req && mem_ready) begin
                m_issued = 1; mem_pend = 1; mem_cnt = $urandom_range(0, 2);
            end else if (mem_rvalid) begin
                m_out = 0; mem_pend = 0;
            end else if (mem_pend) begin
                mem_cnt--;
            end
        end
        #1;
        chk("rnd_no_proto", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
